fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction fetch stage directly upstream of the instruction decoder.
//   Holds the PC, fetches one 32-bit word per instruction over a req/ack
//   instruction-memory handshake, registers it, and presents it with
//   op/funct/rd fields pre-split for the decoder.
//   Accepts PC redirects (branch / PC-write) from the execute side; wrong-path
//   words are discarded.
// PARAMETERS
//   ADDR_W    32     width of PC and instruction-memory address
//   RESET_PC  0      PC loaded on reset (bits [1:0] must be 0)
// PORTS
//   clk          in   1       clock; all state updates on rising edge
//   rst_n        in   1       asynchronous, active-low reset
//   imem_req     out  1       fetch request to instruction memory
//   imem_addr    out  ADDR_W  fetch address; equals pc while imem_req=1
//   imem_ack     in   1       memory returns imem_rdata this cycle
//   imem_rdata   in   32      instruction word, valid only when imem_ack=1
//   instr_valid  out  1       instr/op/funct/rd/pc hold a valid instruction
//   instr_ready  in   1       decode side consumes instr this cycle
//   instr        out  32      registered instruction word
//   cond         out  4       instr[31:28]
//   op           out  2       instr[27:26]
//   funct        out  6       instr[25:20]
//   rd           out  4       instr[15:12]
//   pc           out  ADDR_W  address of instr / of the outstanding fetch
//   pc_plus8     out  ADDR_W  pc + 8 (architectural PC read value)
//   redirect     in   1       load new PC; current instr counts as consumed
//   redirect_pc  in   ADDR_W  redirect target; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, pc=RESET_PC, instr=0,
//     imem_req=0, instr_valid=0, pending_pc=0. An outstanding request is
//     abandoned; the memory must tolerate req dropping without ack.
//   States: IDLE, FETCH, VALID, DRAIN (2-bit register).
//   IDLE : imem_req=0. Next cycle -> FETCH unconditionally. Only entered via reset.
//   FETCH: imem_req=1, imem_addr=pc.
//     ack & !redirect -> instr<=imem_rdata, -> VALID.
//     ack &  redirect -> data discarded, pc<=redirect_pc, stay FETCH (req stays 1).
//     !ack & redirect -> pending_pc<=redirect_pc, -> DRAIN.
//     !ack & !redirect -> hold; imem_addr must not change while req=1.
//   DRAIN: imem_req=1, imem_addr=pc (old, wrong-path).
//     Another redirect -> pending_pc overwritten (last wins).
//     ack -> data discarded, pc<=pending_pc (or redirect_pc if redirect same
//     cycle), -> FETCH.
//   VALID: imem_req=0, instr_valid=1.
//     redirect (priority over ready) -> pc<=redirect_pc, -> FETCH.
//     instr_ready -> pc<=pc+4, -> FETCH.
//     neither -> hold instr and pc stable.
//   instr_valid=1 only in VALID; imem_ack outside FETCH/DRAIN is ignored.
//   Latency: ack in cycle N -> instr_valid=1 in N+1. Peak rate 1 instr / 2 cycles.
//   Arithmetic: pc+4, pc+8 modulo 2^ADDR_W (0xFFFFFFFC+4 -> 0x00000000).
//   cond/op/funct/rd are combinational slices of the instr register.
// TESTING
//   Reset release, ack after 1 cycle, rdata=0xE0812003 -> imem_addr=0x0,
//     instr_valid next cycle, op=0, funct=0x08, rd=2, pc_plus8=0x8.
//   Stream 3 words, ready held 1, ack same cycle as req -> addr 0x0,0x4,0x8;
//     valid every 2nd cycle.
//   VALID with ready=0 for 5 cycles -> instr, pc, instr_valid stable;
//     imem_req=0 throughout.
//   Redirect to 0x103 in FETCH, ack 3 cycles later -> DRAIN, word discarded,
//     instr_valid stays 0, next imem_addr=0x100.
//   Redirect + ready in VALID, redirect_pc=0x40 -> next imem_addr=0x40 (not pc+4).
//   pc=0xFFFFFFFC consumed -> next fetch 0x0; rst_n low mid-FETCH -> req=0,
//     pc=RESET_PC at once.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: one req/ack fetch per instruction, registered word out one cycle after ack.
// Backpressure: instr held in VALID until instr_ready or redirect; no new fetch is issued meanwhile.
module fetch_stage #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr,
   output logic [3:0]        cond,
   output logic [1:0]        op,
   output logic [5:0]        funct,
   output logic [3:0]        rd,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus8,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_VALID = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [ADDR_W-1:0] r_pending_pc;
   logic [ADDR_W-1:0] w_pending_nxt;
   logic [31:0]       r_instr;
   logic [31:0]       w_instr_nxt;
   logic [ADDR_W-1:0] w_redirect_tgt;

   // Targets are word aligned; the low two bits of redirect_pc are dropped.
   assign w_redirect_tgt = redirect_pc & ~ADDR_W'(3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_pending_pc <= '0;
         r_instr      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_pending_pc <= w_pending_nxt;
         r_instr      <= w_instr_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_pending_nxt = r_pending_pc;
      w_instr_nxt   = r_instr;
      case (r_state)
         S_IDLE: w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (imem_ack && !redirect) begin
               w_instr_nxt = imem_rdata;
               w_state_nxt = S_VALID;
            end else if (imem_ack && redirect) begin
               w_pc_nxt = w_redirect_tgt;
            end else if (redirect) begin
               // Request already in flight at the old pc: wait for its ack before refetching.
               w_pending_nxt = w_redirect_tgt;
               w_state_nxt   = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (redirect) w_pending_nxt = w_redirect_tgt;
            if (imem_ack) begin
               w_pc_nxt    = redirect ? w_redirect_tgt : r_pending_pc;
               w_state_nxt = S_FETCH;
            end
         end
         S_VALID: begin
            if (redirect) begin
               w_pc_nxt    = w_redirect_tgt;
               w_state_nxt = S_FETCH;
            end else if (instr_ready) begin
               w_pc_nxt    = r_pc + ADDR_W'(4);
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign imem_req    = (r_state == S_FETCH) || (r_state == S_DRAIN);
   assign imem_addr   = r_pc;
   assign instr_valid = (r_state == S_VALID);
   assign instr       = r_instr;
   assign cond        = r_instr[31:28];
   assign op          = r_instr[27:26];
   assign funct       = r_instr[25:20];
   assign rd          = r_instr[15:12];
   assign pc          = r_pc;
   assign pc_plus8    = r_pc + ADDR_W'(8);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: transaction-level model compared every cycle, plus literal checks.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [3:0]  cond;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic [3:0]  rd;
   logic [31:0] pc;
   logic [31:0] pc_plus8;
   logic        redirect;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .cond(cond), .op(op), .funct(funct), .rd(rd),
      .pc(pc), .pc_plus8(pc_plus8),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: what the fetch unit is doing in terms of "address being fetched",
   // "word held for decode", and "outstanding fetch is wrong-path".
   logic        m_started, m_held, m_wrong;
   logic [31:0] m_pc, m_word, m_target;

   function automatic logic [31:0] align(input logic [31:0] a);
      return (a / 4) * 4;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_started <= 1'b0; m_held <= 1'b0; m_wrong <= 1'b0;
         m_pc <= 32'h0; m_word <= 32'h0; m_target <= 32'h0;
      end else if (!m_started) begin
         m_started <= 1'b1;
      end else if (m_held) begin
         if (redirect) begin
            m_pc <= align(redirect_pc); m_held <= 1'b0;
         end else if (instr_ready) begin
            m_pc <= m_pc + 32'd4; m_held <= 1'b0;
         end
      end else if (m_wrong) begin
         if (redirect) m_target <= align(redirect_pc);
         if (imem_ack) begin
            m_pc    <= redirect ? align(redirect_pc) : m_target;
            m_wrong <= 1'b0;
         end
      end else if (imem_ack) begin
         if (redirect) m_pc <= align(redirect_pc);
         else begin
            m_held <= 1'b1; m_word <= imem_rdata;
         end
      end else if (redirect) begin
         m_wrong <= 1'b1; m_target <= align(redirect_pc);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_req", 32'(imem_req), 32'(m_started && !m_held));
         if (imem_req) chk("m_addr", imem_addr, m_pc);
         chk("m_valid", 32'(instr_valid), 32'(m_held));
         chk("m_instr", instr, m_word);
         chk("m_cond", 32'(cond), m_word >> 28);
         chk("m_op", 32'(op), (m_word >> 26) % 4);
         chk("m_funct", 32'(funct), (m_word >> 20) % 64);
         chk("m_rd", 32'(rd), (m_word >> 12) % 16);
         chk("m_pc", pc, m_pc);
         chk("m_pc8", pc_plus8, m_pc + 32'd8);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   logic [31:0] words [3];
   logic [31:0] seen_addr [$];

   initial begin
      words[0] = 32'hE0812003; words[1] = 32'h11223344; words[2] = 32'hA5A5F00D;
      imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
      redirect = 1'b0; redirect_pc = 32'h0;
      rst_n = 1'b0;
      tick(2);
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);

      // First fetch, ack after one wait cycle
      rst_n = 1'b1;
      tick(1);
      chk("t1_req", 32'(imem_req), 32'h1);
      chk("t1_addr", imem_addr, 32'h0);
      tick(1);
      imem_ack = 1'b1; imem_rdata = 32'hE0812003;
      tick(1);
      imem_ack = 1'b0; imem_rdata = 32'hDEADBEEF;
      chk("t1_valid", 32'(instr_valid), 32'h1);
      chk("t1_op", 32'(op), 32'h0);
      chk("t1_funct", 32'(funct), 32'h08);
      chk("t1_rd", 32'(rd), 32'h2);
      chk("t1_pc8", pc_plus8, 32'h8);

      // Streaming with ready held high and same-cycle ack
      do_reset();
      tick(1);
      for (int i = 0; i < 5; i++) begin
         chk("t2_valid_pattern", 32'(instr_valid), 32'(i % 2));
         instr_ready = 1'b1;
         imem_ack    = imem_req;
         if (imem_req) begin
            seen_addr.push_back(imem_addr);
            imem_rdata = words[seen_addr.size() - 1];
         end
         tick(1);
      end
      imem_ack = 1'b0; instr_ready = 1'b0;
      chk("t2_naddr", 32'(seen_addr.size()), 32'd3);
      chk("t2_addr0", seen_addr[0], 32'h0);
      chk("t2_addr1", seen_addr[1], 32'h4);
      chk("t2_addr2", seen_addr[2], 32'h8);

      // Decoder stalls for five cycles
      for (int i = 0; i < 5; i++) begin
         chk("t3_valid", 32'(instr_valid), 32'h1);
         chk("t3_req", 32'(imem_req), 32'h0);
         chk("t3_pc", pc, 32'h8);
         chk("t3_instr", instr, 32'hA5A5F00D);
         tick(1);
      end
      instr_ready = 1'b1;
      tick(1);
      instr_ready = 1'b0;
      chk("t3_next_addr", imem_addr, 32'hC);

      // Redirect while a fetch is outstanding; wrong-path ack three cycles later
      redirect = 1'b1; redirect_pc = 32'h103;
      tick(1);
      redirect = 1'b0;
      chk("t4_drain_addr", imem_addr, 32'hC);
      tick(1);
      imem_ack = 1'b1; imem_rdata = 32'hBADBAD00;
      tick(1);
      imem_ack = 1'b0;
      chk("t4_valid", 32'(instr_valid), 32'h0);
      chk("t4_addr", imem_addr, 32'h100);
      imem_ack = 1'b1; imem_rdata = 32'h0000A000;
      tick(1);
      imem_ack = 1'b0;
      chk("t4_pc", pc, 32'h100);

      // Redirect beats ready in VALID
      redirect = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
      tick(1);
      redirect = 1'b0; instr_ready = 1'b0;
      chk("t5_addr", imem_addr, 32'h40);
      chk("t5_valid", 32'(instr_valid), 32'h0);

      // Ack together with redirect in FETCH: data dropped, refetch at target
      imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFFFFFE;
      tick(1);
      imem_ack = 1'b0; redirect = 1'b0;
      chk("t6_valid", 32'(instr_valid), 32'h0);
      chk("t6_addr", imem_addr, 32'hFFFFFFFC);
      imem_ack = 1'b1; imem_rdata = 32'h12345678;
      tick(1);
      imem_ack = 1'b0;
      chk("t6_pc8_wrap", pc_plus8, 32'h4);
      instr_ready = 1'b1;
      tick(1);
      instr_ready = 1'b0;
      chk("t6_wrap_addr", imem_addr, 32'h0);

      // Async reset mid-FETCH
      #1 rst_n = 1'b0;
      #1;
      chk("t7_req", 32'(imem_req), 32'h0);
      chk("t7_pc", pc, 32'h0);
      chk("t7_valid", 32'(instr_valid), 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
